// File: rtl/reg_file_sb.sv
// Register file with per-register busy scoreboard and registered busy count.
// Optional same-cycle writeback bypass on both read ports under REGFILE_BYPASS_EN.
module reg_file_sb #(
    parameter int unsigned     XLEN    = 32,
    parameter int unsigned     NREGS   = 32,
    parameter logic [XLEN-1:0] SP_INIT = XLEN'(32'h0101_1111),
    localparam int unsigned    AW      = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic [AW-1:0]   busy_cnt
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic [NREGS-1:0] busy_q, busy_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic             wb_hit, iss_hit, cnt_inc, cnt_dec;

    // Register 0 is hardwired: writes and issues to it are dropped here.
    assign wb_hit  = wb_en && (wb_addr != '0);
    assign iss_hit = iss_valid && (iss_rd != '0) && !flush;

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        cnt_d  = cnt_q;
        if (wb_hit) begin
            regs_d[wb_addr] = wb_data;
            busy_d[wb_addr] = 1'b0;
        end
        if (iss_hit) begin
            busy_d[iss_rd] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
        // A new producer for the register being written back keeps it busy.
        cnt_inc = iss_hit && !busy_q[iss_rd];
        cnt_dec = wb_hit && busy_q[wb_addr] && !(iss_hit && (iss_rd == wb_addr));
        if (flush) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + AW'(cnt_inc) - AW'(cnt_dec);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= (i == 2) ? SP_INIT : '0;
            end
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        rs1_data = (rs1_addr == '0) ? '0 : regs_q[rs1_addr];
        rs2_data = (rs2_addr == '0) ? '0 : regs_q[rs2_addr];
        rs1_busy = busy_q[rs1_addr];
        rs2_busy = busy_q[rs2_addr];
`ifdef REGFILE_BYPASS_EN
        // Forward the in-flight writeback; a same-cycle issue re-marks it busy.
        if (wb_hit && (wb_addr == rs1_addr)) begin
            rs1_data = wb_data;
            rs1_busy = iss_valid && (iss_rd == rs1_addr);
        end
        if (wb_hit && (wb_addr == rs2_addr)) begin
            rs2_data = wb_data;
            rs2_busy = iss_valid && (iss_rd == rs2_addr);
        end
`endif
    end

    assign busy_cnt = cnt_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: per-cycle model comparison plus literal checkpoints.
module tb_reg_file_sb;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned AW    = 5;
    localparam logic [31:0] SP    = 32'h0101_1111;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [AW-1:0]   rs1_addr, rs2_addr, iss_rd, wb_addr;
    logic [XLEN-1:0] rs1_data, rs2_data, wb_data;
    logic            rs1_busy, rs2_busy, iss_valid, wb_en, flush;
    logic [AW-1:0]   busy_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_regs [NREGS];
    bit          m_busy [NREGS];

    reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .SP_INIT(SP)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .flush(flush), .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Architectural model: state per register, count derived by summation.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                m_regs[i] = (i == 2) ? SP : 32'h0;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (wb_en && wb_addr != 0) begin
                m_regs[wb_addr] = wb_data;
                m_busy[wb_addr] = 1'b0;
            end
            if (flush) begin
                for (int i = 0; i < int'(NREGS); i++) m_busy[i] = 1'b0;
            end else if (iss_valid && iss_rd != 0) begin
                m_busy[iss_rd] = 1'b1;
            end
        end
    end

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < int'(NREGS); i++) c += int'(m_busy[i]);
        return c;
    endfunction

    function automatic logic [31:0] m_rdata(input logic [AW-1:0] a);
        if (a == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (wb_en && wb_addr == a) return wb_data;
`endif
        return m_regs[a];
    endfunction

    function automatic logic m_rbusy(input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (wb_en && wb_addr == a) return iss_valid && iss_rd == a;
`endif
        return m_busy[a];
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("cmp_rs1_data", rs1_data, m_rdata(rs1_addr));
            check("cmp_rs2_data", rs2_data, m_rdata(rs2_addr));
            check("cmp_rs1_busy", 32'(rs1_busy), 32'(m_rbusy(rs1_addr)));
            check("cmp_rs2_busy", 32'(rs2_busy), 32'(m_rbusy(rs2_addr)));
            check("cmp_busy_cnt", 32'(busy_cnt), 32'(m_count()));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        iss_valid = 1'b0; iss_rd = '0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        flush = 1'b0;
    endtask

    task automatic issue(input int rd);
        idle();
        iss_valid = 1'b1; iss_rd = AW'(rd);
    endtask

    task automatic wb(input int a, input logic [31:0] d);
        wb_en = 1'b1; wb_addr = AW'(a); wb_data = d;
    endtask

    initial begin
        rst_n = 1'b0;
        rs1_addr = '0; rs2_addr = '0;
        idle();
        cyc(); cyc();
        rst_n = 1'b1;
        rs1_addr = 5'd2; rs2_addr = 5'd5;
        #1;
        check("rst_sp", rs1_data, 32'h0101_1111);
        check("rst_r5", rs2_data, 32'h0);
        check("rst_cnt", 32'(busy_cnt), 32'd0);

        // register 0 ignores writes and issues
        cyc(); issue(0); wb(0, 32'hDEAD_BEEF); rs1_addr = '0; rs2_addr = '0;
        cyc(); idle(); #1;
        check("r0_data", rs1_data, 32'h0);
        check("r0_busy", 32'(rs1_busy), 32'd0);
        check("r0_cnt", 32'(busy_cnt), 32'd0);

        cyc(); issue(5);
        cyc(); issue(7);
        cyc(); idle(); rs1_addr = 5'd5; #1;
        check("two_busy_cnt", 32'(busy_cnt), 32'd2);
        check("r5_busy", 32'(rs1_busy), 32'd1);
        cyc(); wb(5, 32'h1234);
        cyc(); idle(); #1;
        check("r5_data", rs1_data, 32'h1234);
        check("r5_free", 32'(rs1_busy), 32'd0);
        check("cnt_after_wb", 32'(busy_cnt), 32'd1);

        // same-cycle issue and writeback: new producer wins
        cyc(); issue(9); wb(9, 32'h55);
        cyc(); idle(); rs1_addr = 5'd9; #1;
        check("r9_data", rs1_data, 32'h55);
        check("r9_busy", 32'(rs1_busy), 32'd1);
        check("r9_cnt", 32'(busy_cnt), 32'd2);

        cyc(); idle(); wb(3, 32'hA5A5); rs2_addr = 5'd3; #1;
`ifdef REGFILE_BYPASS_EN
        check("r3_same_cycle", rs2_data, 32'hA5A5);
`else
        check("r3_same_cycle", rs2_data, 32'h0);
`endif
        cyc(); idle(); #1;
        check("r3_next_cycle", rs2_data, 32'hA5A5);

        cyc(); issue(4);
        cyc(); issue(6);
        cyc(); issue(8);
        cyc(); idle(); #1;
        check("five_busy_cnt", 32'(busy_cnt), 32'd5);
        cyc(); issue(10); wb(4, 32'h77); flush = 1'b1;
        cyc(); idle(); rs1_addr = 5'd10; rs2_addr = 5'd4; #1;
        check("flush_cnt", 32'(busy_cnt), 32'd0);
        check("flush_r10_busy", 32'(rs1_busy), 32'd0);
        check("flush_r4_data", rs2_data, 32'h77);
        check("flush_r4_busy", 32'(rs2_busy), 32'd0);

        // writeback to a free register leaves the count alone
        cyc(); wb(11, 32'h11);
        cyc(); idle(); rs1_addr = 5'd11; #1;
        check("wb_free_cnt", 32'(busy_cnt), 32'd0);
        check("wb_free_data", rs1_data, 32'h11);
        cyc(); issue(12);
        cyc(); issue(12);
        cyc(); idle(); #1;
        check("reissue_cnt", 32'(busy_cnt), 32'd1);
        cyc(); issue(13); wb(12, 32'hC);
        cyc(); idle(); rs1_addr = 5'd12; rs2_addr = 5'd13; #1;
        check("swap_cnt", 32'(busy_cnt), 32'd1);
        check("swap_r12_busy", 32'(rs1_busy), 32'd0);
        check("swap_r13_busy", 32'(rs2_busy), 32'd1);

        // fill every register: count saturates at NREGS-1
        for (int r = 1; r < int'(NREGS); r++) begin
            cyc(); issue(r);
        end
        cyc(); idle(); #1;
        check("full_cnt", 32'(busy_cnt), 32'd31);
        cyc(); issue(31);
        cyc(); issue(20); wb(20, 32'h2020);
        cyc(); idle(); rs1_addr = 5'd20; #1;
        check("full_hold_cnt", 32'(busy_cnt), 32'd31);
        check("full_r20_data", rs1_data, 32'h2020);

        // reset in the middle of pending traffic
        cyc(); idle(); flush = 1'b1;
        cyc(); issue(15); wb(16, 32'hBEEF); rs1_addr = 5'd16; rs2_addr = 5'd2;
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_cnt", 32'(busy_cnt), 32'd0);
        check("mid_rst_sp", rs2_data, 32'h0101_1111);
        cyc(); idle();
        cyc(); rst_n = 1'b1; rs2_addr = 5'd15; #1;
        check("post_rst_r16", rs1_data, 32'h0);
        check("post_rst_r15_busy", 32'(rs2_busy), 32'd0);
        check("post_rst_cnt", 32'(busy_cnt), 32'd0);
        rs1_addr = 5'd5; #1;
        check("post_rst_r5", rs1_data, 32'h0);
        cyc(); cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 Parameter XLEN, 32, data width in bits of every register.
REQ-002 Parameter NREGS, 32, number of architectural registers (power of two, 8..64); AW = log2(NREGS).
REQ-003 Parameter SP_INIT, 32'h0101_1111, reset value of register 2 (stack pointer).
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 Ports rs1_addr, rs2_addr  input  AW  read port addresses.
REQ-007 Ports rs1_data, rs2_data  output  XLEN  read data, combinational from address.
REQ-008 Ports rs1_busy, rs2_busy  output  1  addressed register has an outstanding producer.
REQ-009 Port iss_valid  input  1  an instruction writing iss_rd issues this cycle.
REQ-010 Port iss_rd  input  AW  destination of the issuing instruction.
REQ-011 Port wb_en  input  1  writeback strobe.
REQ-012 Ports wb_addr  input  AW, wb_data  input  XLEN  writeback destination and value.
REQ-013 Port flush  input  1  pipeline flush; discards all outstanding producers.
REQ-014 Port busy_cnt  output  AW  registered count of busy registers.

Function
REQ-015 Register array NREGS x XLEN; two combinational read ports, one synchronous write port.
REQ-016 Register 0 SHALL read 0, never be written, never be busy; iss/wb targeting 0 are ignored.
REQ-017 wb_en=1, wb_addr!=0: array[wb_addr] <= wb_data at clock edge; busy[wb_addr] cleared.
REQ-018 iss_valid=1, iss_rd!=0: busy[iss_rd] set at clock edge.
REQ-019 Issue and writeback to same nonzero register in one cycle: data written, busy stays 1 (new producer wins).
REQ-020 Issue to an already-busy register: busy stays 1, busy_cnt unchanged.
REQ-021 Writeback to a non-busy register: data written, busy_cnt unchanged (no underflow).
REQ-022 flush=1: all busy bits cleared and busy_cnt <= 0 at the edge; same-cycle issue ignored; same-cycle writeback data still written.
REQ-023 busy_cnt SHALL equal the number of set busy bits at every edge; increment/decrement/hold per REQ-018..022; maximum NREGS-1, no wrap.
REQ-024 rsN_busy = busy[rsN_addr] from registered state unless modified by REQ-026.

Reset
REQ-025 rst_n=0 asynchronously: all registers 0 except register 2 = SP_INIT; all busy bits 0; busy_cnt 0; reset asserted mid-operation discards pending writes and issues; first update on first rising edge after rst_n=1.

Configuration
REQ-026 Macro REGFILE_BYPASS_EN defined: if wb_en=1, wb_addr!=0 and wb_addr==rsN_addr, rsN_data = wb_data and rsN_busy = 0 combinationally (unless iss_valid with iss_rd==rsN_addr, then busy=1); bypass applies to both ports independently.
REQ-027 Macro undefined: rsN_data and rsN_busy reflect registered state only; written value visible the cycle after the edge.

Verification
REQ-028 Release reset; read addr 2 and 5 -> 32'h0101_1111 and 0; busy_cnt 0.
REQ-029 wb_en=1 addr 0 data 32'hDEAD_BEEF; iss_valid rd 0 -> reg 0 reads 0, rs busy 0, busy_cnt 0.
REQ-030 Issue rd 5, next cycle issue rd 7 -> busy_cnt 2; wb addr 5 data 32'h1234 -> rs1_addr 5 reads 32'h1234 busy 0, busy_cnt 1.
REQ-031 Same cycle iss rd 9 and wb addr 9 data 32'h55 (9 not busy) -> reg 9 = 32'h55, busy 1, busy_cnt +1.
REQ-032 With REGFILE_BYPASS_EN: wb addr 3 data 32'hA5A5 while rs2_addr 3 -> rs2_data 32'hA5A5 same cycle; without macro -> old value that cycle, 32'hA5A5 next.
REQ-033 Busy regs 4,6,8, then flush with iss rd 10 and wb addr 4 data 32'h77 -> busy_cnt 0, reg 10 not busy, reg 4 = 32'h77; assert rst_n mid-sequence -> outputs at reset values immediately.
